// File: rtl/vc_flit_buffer_pkg.sv
// Shared flit definitions for the virtual-channel flit buffer: type codes,
// field positions, the IDLE flit constant and the per-VC packet state type.
package vc_flit_buffer_pkg;

    localparam int FLIT_TYPE_MSB = 31;
    localparam int FLIT_TYPE_LSB = 30;

    localparam logic [1:0] FLIT_HEAD = 2'b00;
    localparam logic [1:0] FLIT_IDLE = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    localparam logic [31:0] IDLE_FLIT = 32'h6000_0000;

    typedef enum logic {
        PKT_IDLE   = 1'b0,
        PKT_ACTIVE = 1'b1
    } pkt_state_e;

    function automatic logic [1:0] flit_type(input logic [31:0] flit);
        return flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB];
    endfunction

endpackage

// File: rtl/vc_flit_buffer_fifo.sv
// Single-VC synchronous FIFO; full/empty are registered from the next count
// so they always describe the stored occupancy seen at the next edge.
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage carries no reset: occupancy is defined solely by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/vc_flit_buffer.sv
// Per-input-port VC flit buffer: one FIFO per VC, round-robin dequeue into a
// registered output with load strobe and per-VC credit return.
// Optional packet-protocol checking is enabled by defining VC_PROTO_CHECK_EN.
module vc_flit_buffer
    import vc_flit_buffer_pkg::*;
#(
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 4,
    parameter int VC_W   = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       din,
    input  logic              din_valid,
    input  logic [VC_W-1:0]   din_vc,
    output logic [31:0]       dout,
    output logic [VC_W-1:0]   dout_vc,
    output logic              dout_ce,
    input  logic              dout_ready,
    output logic [NUM_VC-1:0] credit_out,
    output logic [NUM_VC-1:0] vc_empty,
    output logic [NUM_VC-1:0] vc_full,
    output logic              proto_err
);
    logic [1:0]        wr_type;
    logic              wr_store;
    logic [NUM_VC-1:0] wr_sel, push, pop, fifo_full, fifo_empty;
    logic [31:0]       head [NUM_VC];
    logic              overflow, proto_viol;
    logic [VC_W-1:0]   cand;
    logic              cand_vld;

    logic [31:0]       dout_q;
    logic [VC_W-1:0]   dout_vc_q, rr_q;
    logic              dout_ce_q, err_q;
    logic [NUM_VC-1:0] credit_q;

    assign wr_type  = flit_type(din);
    assign wr_store = din_valid && (wr_type != FLIT_IDLE);

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign wr_sel[v] = wr_store && (din_vc == VC_W'(v));
        assign push[v]   = wr_sel[v] && !fifo_full[v];
        assign pop[v]    = dout_ready && cand_vld && (cand == VC_W'(v));

        vc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
            .clk         (clk),
            .clr         (clr),
            .push_i      (push[v]),
            .push_data_i (din),
            .pop_i       (pop[v]),
            .head_o      (head[v]),
            .full_o      (fifo_full[v]),
            .empty_o     (fifo_empty[v])
        );
    end

    // Full is the registered pre-edge flag, so a full VC being read this
    // cycle still refuses the write.
    assign overflow = |(wr_sel & fifo_full);

    always_comb begin
        logic [VC_W-1:0] idx;
        cand     = '0;
        cand_vld = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = rr_q + VC_W'(i);
            if (!cand_vld && !fifo_empty[idx]) begin
                cand     = idx;
                cand_vld = 1'b1;
            end
        end
    end

`ifdef VC_PROTO_CHECK_EN
    pkt_state_e pkt_q [NUM_VC];
    pkt_state_e pkt_cur;

    assign pkt_cur    = pkt_q[din_vc];
    assign proto_viol = (|push) &&
                        (((pkt_cur == PKT_IDLE) && (wr_type != FLIT_HEAD)) ||
                         ((pkt_cur == PKT_ACTIVE) && (wr_type == FLIT_HEAD)));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int v = 0; v < NUM_VC; v++) pkt_q[v] <= PKT_IDLE;
        end else if (|push) begin
            case (wr_type)
                FLIT_HEAD: pkt_q[din_vc] <= PKT_ACTIVE;
                FLIT_TAIL: pkt_q[din_vc] <= PKT_IDLE;
                default:   pkt_q[din_vc] <= pkt_q[din_vc];
            endcase
        end
    end
`else
    assign proto_viol = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dout_q    <= IDLE_FLIT;
            dout_vc_q <= '0;
            dout_ce_q <= 1'b0;
            credit_q  <= '0;
            rr_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            dout_ce_q <= cand_vld && dout_ready;
            credit_q  <= pop;
            if (cand_vld && dout_ready) begin
                dout_q    <= head[cand];
                dout_vc_q <= cand;
                rr_q      <= cand + VC_W'(1);
            end
            if (overflow || proto_viol) err_q <= 1'b1;
        end
    end

    assign dout       = dout_q;
    assign dout_vc    = dout_vc_q;
    assign dout_ce    = dout_ce_q;
    assign credit_out = credit_q;
    assign vc_empty   = fifo_empty;
    assign vc_full    = fifo_full;
    assign proto_err  = err_q;

endmodule

// File: tb/tb_vc_flit_buffer.sv
// Randomized bench for vc_flit_buffer against a queue-based reference model,
// plus directed scenarios with hand-computed expectations.
module tb_vc_flit_buffer;
    localparam int NUM_VC = 2;
    localparam int DEPTH  = 4;
    localparam int VC_W   = 1;
`ifdef VC_PROTO_CHECK_EN
    localparam logic EXP_PROTO = 1'b1;
`else
    localparam logic EXP_PROTO = 1'b0;
`endif

    logic              clk, clr;
    logic [31:0]       din;
    logic              din_valid;
    logic [VC_W-1:0]   din_vc;
    logic [31:0]       dout;
    logic [VC_W-1:0]   dout_vc;
    logic              dout_ce;
    logic              dout_ready;
    logic [NUM_VC-1:0] credit_out, vc_empty, vc_full;
    logic              proto_err;

    vc_flit_buffer #(.NUM_VC(NUM_VC), .DEPTH(DEPTH), .VC_W(VC_W)) dut (
        .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_vc(din_vc),
        .dout(dout), .dout_vc(dout_vc), .dout_ce(dout_ce), .dout_ready(dout_ready),
        .credit_out(credit_out), .vc_empty(vc_empty), .vc_full(vc_full),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]       mq [NUM_VC][$];
    bit                m_active [NUM_VC];
    int                m_rr;
    logic [31:0]       e_dout;
    int                e_vc;
    logic              e_ce, e_err;
    logic [NUM_VC-1:0] e_credit;

    logic [32:0] seen [$];
    int          cred0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NUM_VC; v++) begin
            mq[v].delete();
            m_active[v] = 1'b0;
        end
        m_rr = 0; e_dout = 32'h6000_0000; e_vc = 0; e_ce = 1'b0; e_err = 1'b0; e_credit = '0;
    endtask

    task automatic model_edge();
        int  cand, wv;
        bit  found, do_push;
        logic [1:0] t;
        found = 1'b0; cand = 0; do_push = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            int v;
            v = (m_rr + i) % NUM_VC;
            if (!found && mq[v].size() > 0) begin found = 1'b1; cand = v; end
        end
        wv = int'(din_vc);
        t  = din[31:30];
        if (din_valid && t != 2'b01) begin
            if (mq[wv].size() == DEPTH) e_err = 1'b1;
            else do_push = 1'b1;
        end
        e_credit = '0;
        if (dout_ready && found) begin
            e_dout = mq[cand].pop_front();
            e_vc = cand; e_ce = 1'b1; e_credit[cand] = 1'b1;
            m_rr = (cand + 1) % NUM_VC;
        end else begin
            e_ce = 1'b0;
        end
        if (do_push) begin
`ifdef VC_PROTO_CHECK_EN
            if ((!m_active[wv] && t != 2'b00) || (m_active[wv] && t == 2'b00)) e_err = 1'b1;
`endif
            if (t == 2'b00) m_active[wv] = 1'b1;
            else if (t == 2'b11) m_active[wv] = 1'b0;
            mq[wv].push_back(din);
        end
    endtask

    task automatic compare();
        logic [NUM_VC-1:0] ee, ef;
        for (int v = 0; v < NUM_VC; v++) begin
            ee[v] = (mq[v].size() == 0);
            ef[v] = (mq[v].size() == DEPTH);
        end
        chk("dout", dout, e_dout);
        chk("dout_vc", 32'(dout_vc), 32'(e_vc));
        chk("dout_ce", 32'(dout_ce), 32'(e_ce));
        chk("credit_out", 32'(credit_out), 32'(e_credit));
        chk("vc_empty", 32'(vc_empty), 32'(ee));
        chk("vc_full", 32'(vc_full), 32'(ef));
        chk("proto_err", 32'(proto_err), 32'(e_err));
        if (dout_ce) seen.push_back({dout_vc, dout});
        cred0 += int'(credit_out[0]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic v, input int vc, input logic [31:0] d, input logic rdy);
        din_valid = v; din_vc = VC_W'(vc); din = d; dout_ready = rdy;
        step();
    endtask

    // Asynchronous mid-cycle reset, checked before any clock edge arrives.
    task automatic do_reset();
        din_valid = 1'b0; dout_ready = 1'b0;
        #2 clr = 1'b1;
        #1;
        chk("rst_dout", dout, 32'h6000_0000);
        chk("rst_dout_ce", 32'(dout_ce), 32'h0);
        chk("rst_vc_empty", 32'(vc_empty), 32'h3);
        chk("rst_vc_full", 32'(vc_full), 32'h0);
        chk("rst_credit", 32'(credit_out), 32'h0);
        chk("rst_proto_err", 32'(proto_err), 32'h0);
        model_reset();
        seen.delete();
        cred0 = 0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] seq;
        clr = 1'b1; din = '0; din_valid = 1'b0; din_vc = '0; dout_ready = 1'b0;
        cred0 = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single VC streaming
        drive(1'b1, 0, 32'h0000_0005, 1'b1);
        drive(1'b1, 0, 32'h8000_0001, 1'b1);
        drive(1'b1, 0, 32'hC000_0002, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 0, 32'h0, 1'b1);
        chk("stream_count", 32'(seen.size()), 32'd3);
        if (seen.size() >= 3) begin
            chk("stream_f0", 32'(seen[0]), 32'h0000_0005);
            chk("stream_f1", 32'(seen[1]), 32'h8000_0001);
            chk("stream_f2", 32'(seen[2]), 32'hC000_0002);
            chk("stream_vc", {29'd0, seen[0][32], seen[1][32], seen[2][32]}, 32'h0);
        end
        chk("stream_credits", 32'(cred0), 32'd3);
        chk("stream_empty0", 32'(vc_empty[0]), 32'h1);

        // Round-robin between two preloaded VCs
        do_reset();
        drive(1'b1, 0, 32'h0000_0100, 1'b0);
        drive(1'b1, 1, 32'h0000_0200, 1'b0);
        drive(1'b1, 0, 32'h8000_0101, 1'b0);
        drive(1'b1, 1, 32'h8000_0201, 1'b0);
        drive(1'b1, 0, 32'hC000_0102, 1'b0);
        drive(1'b1, 1, 32'hC000_0202, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 0, 32'h0, 1'b1);
        chk("rr_count", 32'(seen.size()), 32'd6);
        if (seen.size() >= 6) begin
            seq = '0;
            for (int i = 0; i < 6; i++) seq = {seq[4:0], seen[i][32]};
            chk("rr_vc_seq", 32'(seq), 32'h15);
        end

        // Overflow on a full VC
        do_reset();
        drive(1'b1, 1, 32'h0000_0300, 1'b0);
        drive(1'b1, 1, 32'h8000_0301, 1'b0);
        drive(1'b1, 1, 32'h8000_0302, 1'b0);
        drive(1'b1, 1, 32'h8000_0303, 1'b0);
        chk("full_after4", 32'(vc_full[1]), 32'h1);
        chk("no_err_before_ovf", 32'(proto_err), 32'h0);
        drive(1'b1, 1, 32'hC000_0304, 1'b0);
        chk("ovf_err", 32'(proto_err), 32'h1);
        for (int i = 0; i < 6; i++) drive(1'b0, 0, 32'h0, 1'b1);
        chk("ovf_drain_count", 32'(seen.size()), 32'd4);
        chk("ovf_empty1", 32'(vc_empty[1]), 32'h1);

        // Simultaneous read and write on a half-full VC
        do_reset();
        drive(1'b1, 0, 32'h0000_0011, 1'b0);
        drive(1'b1, 0, 32'h8000_0022, 1'b0);
        drive(1'b1, 0, 32'h8000_0033, 1'b1);
        chk("rw_not_empty", 32'(vc_empty[0]), 32'h0);
        for (int i = 0; i < 4; i++) drive(1'b0, 0, 32'h0, 1'b1);
        chk("rw_count", 32'(seen.size()), 32'd3);
        if (seen.size() >= 3) begin
            chk("rw_f0", 32'(seen[0]), 32'h0000_0011);
            chk("rw_f1", 32'(seen[1]), 32'h8000_0022);
            chk("rw_f2", 32'(seen[2]), 32'h8000_0033);
        end

        // BODY into an idle VC, IDLE flit discarded
        do_reset();
        drive(1'b1, 0, 32'h8000_0044, 1'b1);
        drive(1'b1, 1, 32'h6000_0000, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 32'h0, 1'b1);
        chk("body_idle_err", 32'(proto_err), 32'(EXP_PROTO));
        chk("body_idle_count", 32'(seen.size()), 32'd1);
        if (seen.size() >= 1) chk("body_idle_flit", 32'(seen[0]), 32'h8000_0044);

        // Randomized traffic with one mid-run asynchronous reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] t;
            if (n == 1500) do_reset();
            t = 2'($urandom_range(0, 3));
            drive(($urandom_range(0, 99) < 60), int'($urandom_range(0, NUM_VC - 1)),
                  {t, 30'($urandom)}, ($urandom_range(0, 99) < 55));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
